// File: rtl/irq_prio_ctrl.sv
// rtl/irq_prio_ctrl.sv - nested-priority interrupt controller with sync, mask and in-service stack
module irq_prio_ctrl #(
  parameter int N         = 3,
  parameter int VEC_W     = 2,
  parameter bit EDGE_MODE = 1'b1,
  parameter bit NEST_EN   = 1'b1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [N-1:0]     irq,
  input  logic             int_en,
  input  logic             mask_we,
  input  logic [N-1:0]     mask_wdata,
  output logic [N-1:0]     mask,
  output logic [N-1:0]     pending,
  output logic             int_req,
  output logic [VEC_W-1:0] int_id,
  input  logic             int_ack,
  input  logic             int_eret,
  output logic [N-1:0]     int_running
);

  logic [N-1:0] s1_q, s2_q, s3_q;
  logic [N-1:0] pend_q, pend_d;
  logic [N-1:0] mask_q, mask_d;
  logic [N-1:0] run_q, run_d;

  logic [N-1:0]     cand;
  logic [VEC_W-1:0] cid;
  logic [VEC_W-1:0] cur;
  logic             cur_vld;
  logic             req;
  logic [N-1:0]     ack_set;
  logic [N-1:0]     eret_clr;

  assign cand = pend_q & ~mask_q;

  // Ascending scans so the highest set index wins.
  always_comb begin
    cid     = '0;
    cur     = '0;
    cur_vld = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (cand[i]) cid = VEC_W'(i);
      if (run_q[i]) begin
        cur     = VEC_W'(i);
        cur_vld = 1'b1;
      end
    end
  end

  always_comb begin
    req = 1'b0;
    if (int_en && (cand != '0)) begin
      if (NEST_EN) req = !cur_vld || (cid > cur);
      else         req = (run_q == '0);
    end
  end

  assign ack_set  = (int_ack && req)  ? (N'(1) << cid) : '0;
  assign eret_clr = (int_eret && cur_vld) ? (N'(1) << cur) : '0;

  always_comb begin
    mask_d = mask_we ? mask_wdata : mask_q;
    run_d  = (run_q & ~eret_clr) | ack_set;
    if (EDGE_MODE) pend_d = (pend_q & ~ack_set) | (s2_q & ~s3_q);
    else           pend_d = s2_q;
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      s1_q   <= '0;
      s2_q   <= '0;
      s3_q   <= '0;
      pend_q <= '0;
      mask_q <= '0;
      run_q  <= '0;
    end else begin
      s1_q   <= irq;
      s2_q   <= s1_q;
      s3_q   <= s2_q;
      pend_q <= pend_d;
      mask_q <= mask_d;
      run_q  <= run_d;
    end
  end

  assign mask        = mask_q;
  assign pending     = pend_q;
  assign int_req     = req;
  assign int_id      = req ? cid : '0;
  assign int_running = run_q;

endmodule

// File: tb/tb_irq_prio_ctrl.sv
// tb/tb_irq_prio_ctrl.sv - directed checks for edge, level and non-nesting controller variants
module tb_irq_prio_ctrl;

  logic clk = 1'b0;
  logic clr;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // e_: edge+nest, l_: level+nest, n_: edge without nesting
  logic [2:0] e_irq, e_mwd, e_mask, e_pend, e_run;
  logic       e_en, e_mwe, e_req, e_ack, e_eret;
  logic [1:0] e_id;
  logic [2:0] l_irq, l_mwd, l_mask, l_pend, l_run;
  logic       l_en, l_mwe, l_req, l_ack, l_eret;
  logic [1:0] l_id;
  logic [2:0] n_irq, n_mwd, n_mask, n_pend, n_run;
  logic       n_en, n_mwe, n_req, n_ack, n_eret;
  logic [1:0] n_id;

  irq_prio_ctrl #(.N(3), .VEC_W(2), .EDGE_MODE(1'b1), .NEST_EN(1'b1)) u_e (
    .clk(clk), .clr(clr), .irq(e_irq), .int_en(e_en), .mask_we(e_mwe),
    .mask_wdata(e_mwd), .mask(e_mask), .pending(e_pend), .int_req(e_req),
    .int_id(e_id), .int_ack(e_ack), .int_eret(e_eret), .int_running(e_run));

  irq_prio_ctrl #(.N(3), .VEC_W(2), .EDGE_MODE(1'b0), .NEST_EN(1'b1)) u_l (
    .clk(clk), .clr(clr), .irq(l_irq), .int_en(l_en), .mask_we(l_mwe),
    .mask_wdata(l_mwd), .mask(l_mask), .pending(l_pend), .int_req(l_req),
    .int_id(l_id), .int_ack(l_ack), .int_eret(l_eret), .int_running(l_run));

  irq_prio_ctrl #(.N(3), .VEC_W(2), .EDGE_MODE(1'b1), .NEST_EN(1'b0)) u_n (
    .clk(clk), .clr(clr), .irq(n_irq), .int_en(n_en), .mask_we(n_mwe),
    .mask_wdata(n_mwd), .mask(n_mask), .pending(n_pend), .int_req(n_req),
    .int_id(n_id), .int_ack(n_ack), .int_eret(n_eret), .int_running(n_run));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic e_ack_pulse();
    e_ack = 1'b1; tick(1); e_ack = 1'b0;
  endtask

  task automatic e_eret_pulse();
    e_eret = 1'b1; tick(1); e_eret = 1'b0;
  endtask

  initial begin
    clr = 1'b0;
    e_irq = '0; e_mwd = '0; e_en = 1'b1; e_mwe = 1'b0; e_ack = 1'b0; e_eret = 1'b0;
    l_irq = '0; l_mwd = '0; l_en = 1'b1; l_mwe = 1'b0; l_ack = 1'b0; l_eret = 1'b0;
    n_irq = '0; n_mwd = '0; n_en = 1'b1; n_mwe = 1'b0; n_ack = 1'b0; n_eret = 1'b0;
    tick(2);
    check("rst_pend", e_pend, 3'b000);
    check("rst_mask", e_mask, 3'b000);
    check("rst_run",  e_run,  3'b000);
    check("rst_req",  e_req,  1'b0);
    check("rst_id",   e_id,   2'd0);
    clr = 1'b1;
    tick(1);

    // Pre-emption
    e_irq = 3'b001; tick(3);
    check("pre_req0", e_req, 1'b1);
    check("pre_id0",  e_id,  2'd0);
    e_ack_pulse();
    check("pre_run1", e_run, 3'b001);
    check("pre_pclr", e_pend, 3'b000);
    e_irq = 3'b101; tick(3);
    check("pre_req2", e_req, 1'b1);
    check("pre_id2",  e_id,  2'd2);
    e_ack_pulse();
    check("pre_run2", e_run, 3'b101);
    check("pre_noreq", e_req, 1'b0);
    e_eret_pulse();
    check("pre_eret1", e_run, 3'b001);
    e_eret_pulse();
    check("pre_eret2", e_run, 3'b000);
    e_irq = 3'b000; tick(3);

    // Low priority arrives during high-priority service
    e_irq = 3'b100; tick(3);
    e_ack_pulse();
    check("low_run", e_run, 3'b100);
    e_irq = 3'b001; tick(4);
    e_irq = 3'b000;
    check("low_pend", e_pend, 3'b001);
    check("low_noreq", e_req, 1'b0);
    e_eret_pulse();
    check("low_req", e_req, 1'b1);
    check("low_id",  e_id,  2'd0);
    e_ack_pulse();
    e_eret_pulse();
    check("low_done", e_run, 3'b000);
    tick(3);

    // Synchroniser latency and simultaneous-rise tie
    e_irq = 3'b101; tick(2);
    check("lat_early", e_pend, 3'b000);
    tick(1);
    check("lat_pend", e_pend, 3'b101);
    check("tie_id", e_id, 2'd2);
    e_ack_pulse();
    check("tie_run", e_run, 3'b100);
    check("tie_noreq", e_req, 1'b0);
    e_eret_pulse();
    check("tie_id0", e_id, 2'd0);
    check("tie_req0", e_req, 1'b1);
    e_ack_pulse();
    e_eret_pulse();
    e_irq = 3'b000; tick(3);

    // Mask and global enable
    e_mwe = 1'b1; e_mwd = 3'b100; tick(1); e_mwe = 1'b0;
    check("msk_val", e_mask, 3'b100);
    e_irq = 3'b100; tick(3);
    check("msk_pend", e_pend, 3'b100);
    check("msk_noreq", e_req, 1'b0);
    e_mwe = 1'b1; e_mwd = 3'b000; tick(1); e_mwe = 1'b0;
    check("msk_req", e_req, 1'b1);
    check("msk_id",  e_id,  2'd2);
    e_en = 1'b0; #1;
    check("en_noreq", e_req, 1'b0);
    check("en_id0",   e_id,  2'd0);
    tick(1);
    check("en_hold", e_pend, 3'b100);
    e_en = 1'b1; #1;
    e_ack_pulse();
    e_eret_pulse();
    e_irq = 3'b000;

    // Level mode
    l_irq = 3'b010; tick(3);
    check("lvl_req", l_req, 1'b1);
    check("lvl_id",  l_id,  2'd1);
    l_ack = 1'b1; tick(1); l_ack = 1'b0;
    check("lvl_run", l_run, 3'b010);
    check("lvl_pend", l_pend, 3'b010);
    check("lvl_noreq", l_req, 1'b0);
    l_eret = 1'b1; tick(1); l_eret = 1'b0;
    check("lvl_rereq", l_req, 1'b1);
    l_irq = 3'b000; tick(2);
    check("lvl_still", l_pend, 3'b010);
    tick(1);
    check("lvl_clr", l_pend, 3'b000);

    // No nesting, then reset mid-service
    n_mwe = 1'b1; n_mwd = 3'b010; tick(1); n_mwe = 1'b0;
    n_irq = 3'b001; tick(3);
    n_ack = 1'b1; tick(1); n_ack = 1'b0;
    check("nn_run0", n_run, 3'b001);
    n_irq = 3'b101; tick(3);
    check("nn_pend", n_pend, 3'b100);
    check("nn_noreq", n_req, 1'b0);
    n_eret = 1'b1; tick(1); n_eret = 1'b0;
    check("nn_req", n_req, 1'b1);
    check("nn_id",  n_id,  2'd2);
    n_ack = 1'b1; tick(1); n_ack = 1'b0;
    check("nn_run2", n_run, 3'b100);
    clr = 1'b0; tick(1);
    check("nr_run",  n_run,  3'b000);
    check("nr_mask", n_mask, 3'b000);
    check("nr_pend", n_pend, 3'b000);
    check("nr_req",  n_req,  1'b0);
    check("nr_id",   n_id,   2'd0);
    clr = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
